hit_arbiter: RTL and testbench
==============================

HIT_ARBITER -- requirements
Module: hit_arbiter

Interface
- REQ-001 SHALL have parameter N_HOLES, default 8: number of mole holes and buttons.
- REQ-002 SHALL have parameter LOCKOUT_CYCLES, default 25_000_000: input-ignore time after a miss (0.5 s at 50 MHz).
- REQ-003 SHALL have port clk, input, 1 bit: DE2-115 50 MHz clock, the only clock.
- REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
- REQ-005 SHALL have port game_en, input, 1 bit: HIGH while a round is running.
- REQ-006 SHALL have port hit_req, input, N_HOLES bits: one-cycle debounced button-press pulses, one bit per hole.
- REQ-007 SHALL have port mole_active, input, N_HOLES bits: current board occupancy from the mole generator.
- REQ-008 SHALL have port miss, output, 1 bit: one-cycle pulse to the combo counter.
- REQ-009 SHALL have port non_full_clear_hit, output, 1 bit: one-cycle pulse to the combo counter.
- REQ-010 SHALL have port full_clear_hit, output, 1 bit: one-cycle pulse to the combo counter.
- REQ-011 SHALL have port clear_mole, output, N_HOLES bits: one-hot one-cycle pulse telling the board to remove the hit mole.
- REQ-012 SHALL have port locked, output, 1 bit: HIGH during the post-miss lockout.

Function
- REQ-013 SHALL OR hit_req into a pending register every cycle; repeated presses on an already-pending hole merge into that one bit.
- REQ-014 SHALL implement an FSM with states IDLE, GRANT, ISSUE, SETTLE and LOCKOUT.
- REQ-015 IDLE: if pending is non-zero, SHALL select one hole round-robin, searching upward from rr_ptr with wrap at N_HOLES; SHALL latch its index as sel; SHALL clear pending[sel]; SHALL go to GRANT.
- REQ-016 GRANT: SHALL sample mole_active and classify the event, then go to ISSUE.
  - hit: mole_active[sel]=1.
  - full clear: a hit AND every other mole_active bit is 0.
  - miss: mole_active[sel]=0.
- REQ-017 ISSUE: exactly one of miss, non_full_clear_hit or full_clear_hit SHALL be HIGH for this single cycle; on any hit, clear_mole SHALL equal one-hot(sel), otherwise 0.
- REQ-018 ISSUE: SHALL set rr_ptr = (sel+1) mod N_HOLES.
- REQ-019 ISSUE: SHALL go to LOCKOUT if the event was a miss, otherwise to SETTLE.
- REQ-020 SETTLE: SHALL last one cycle, giving the board a cycle to drop the cleared mole, then return to IDLE.
- REQ-021 Latency: hit_req in cycle 0 on an idle arbiter SHALL produce the pulse in cycle 3; consecutive queued events SHALL be spaced exactly 4 cycles apart.
- REQ-022 LOCKOUT:
  - SHALL hold locked HIGH for exactly LOCKOUT_CYCLES cycles, counted by a down-counter, then go to IDLE.
  - SHALL hold pending at 0 throughout, discarding hit_req.
  - The counter SHALL be sized ceil(log2(LOCKOUT_CYCLES+1)) bits.
- REQ-023 A hit_req on hole sel arriving during GRANT, ISSUE or SETTLE SHALL set pending again and be arbitrated later; it is normally classified as a miss.
- REQ-024 game_en LOW:
  - SHALL clear pending, the lockout counter and rr_ptr, and force IDLE at the next edge.
  - An event in ISSUE during that cycle SHALL still complete its pulse.
  - No further pulses SHALL occur while game_en is LOW.
- REQ-025 All outputs SHALL be registered; the three event pulses and clear_mole SHALL never be HIGH outside ISSUE.

Reset
- REQ-026 rst HIGH SHALL immediately set state IDLE, pending 0, rr_ptr 0, sel 0, lockout counter 0, and drive all outputs to 0, regardless of clock.
- REQ-027 rst asserted mid-event (GRANT/ISSUE/SETTLE/LOCKOUT) SHALL abandon the event with no pulse after reset release; the first post-release edge SHALL see state IDLE.

Verification
- REQ-028 N=8, mole_active=8'b0000_0101, hit_req[0] pulse cycle 0 -> non_full_clear_hit=1 and clear_mole=8'b0000_0001 in cycle 3 only.
- REQ-029 mole_active=8'b0001_0000, hit_req[4] pulse -> full_clear_hit=1 and clear_mole=8'b0001_0000 in cycle 3; miss=0.
- REQ-030 LOCKOUT_CYCLES=10, mole_active=0, hit_req[2] pulse -> miss in cycle 3, locked HIGH for 10 cycles; hit_req[5] during lockout -> no pulse ever.
- REQ-031 mole_active=8'hFF, hit_req=8'b1000_0011 in one cycle, rr_ptr=0 -> hits for holes 0, 1, 7 in cycles 3, 7, 11 (the board clears bits as commanded).
- REQ-032 rst pulsed during the GRANT of hole 3 -> all outputs 0 immediately, no pulse afterwards, pending empty; a fresh hit_req[3] after release -> pulse 3 cycles later.
- REQ-033 game_en dropped while 3 holes are pending -> no pulses; on game_en re-raise, pending is empty and rr_ptr=0.

Source files
------------

// File: rtl/hit_arbiter.sv
// Whack-a-mole hit arbiter: queues button presses, serves them round-robin, classifies each as
// miss / hit / full-clear hit against the board and enforces a lockout after a miss.
module hit_arbiter #(
  parameter int unsigned N_HOLES        = 8,
  parameter int unsigned LOCKOUT_CYCLES = 25_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               game_en,
  input  logic [N_HOLES-1:0] hit_req,
  input  logic [N_HOLES-1:0] mole_active,
  output logic               miss,
  output logic               non_full_clear_hit,
  output logic               full_clear_hit,
  output logic [N_HOLES-1:0] clear_mole,
  output logic               locked
);

  localparam int unsigned SelW = (N_HOLES > 1) ? $clog2(N_HOLES) : 1;
  localparam int unsigned CntW = (LOCKOUT_CYCLES > 0) ? $clog2(LOCKOUT_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] LoadVal = CntW'(LOCKOUT_CYCLES);

  typedef enum logic [2:0] {StIdle, StGrant, StIssue, StSettle, StLockout} state_e;

  state_e              state_q, state_d;
  logic [N_HOLES-1:0]  pending_q, pending_d;
  logic [SelW-1:0]     sel_q, sel_d;
  logic [SelW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                miss_q, miss_d;
  logic                nfch_q, nfch_d;
  logic                fch_q, fch_d;
  logic [N_HOLES-1:0]  clear_q, clear_d;
  logic                locked_q, locked_d;

  logic                pick_found;
  logic [SelW-1:0]     pick_idx;
  logic [SelW-1:0]     cand;
  logic [N_HOLES-1:0]  sel_oh;
  logic [N_HOLES-1:0]  others;
  logic                is_hit;

  assign sel_oh = N_HOLES'(1) << sel_q;
  assign others = mole_active & ~sel_oh;
  assign is_hit = mole_active[sel_q];

  // First pending hole at or above rr_ptr, wrapping at N_HOLES.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned i = 0; i < N_HOLES; i++) begin
      cand = SelW'((32'(rr_ptr_q) + i) % N_HOLES);
      if (!pick_found && pending_q[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q | hit_req;
    sel_d     = sel_q;
    rr_ptr_d  = rr_ptr_q;
    cnt_d     = cnt_q;
    miss_d    = 1'b0;
    nfch_d    = 1'b0;
    fch_d     = 1'b0;
    clear_d   = '0;
    locked_d  = 1'b0;
    if (!game_en) begin
      state_d   = StIdle;
      pending_d = '0;
      rr_ptr_d  = '0;
      cnt_d     = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pick_found) begin
            sel_d     = pick_idx;
            // A press landing in the same cycle as the grant is kept for later.
            pending_d = (pending_q & ~(N_HOLES'(1) << pick_idx)) | hit_req;
            state_d   = StGrant;
          end
        end
        StGrant: begin
          miss_d  = !is_hit;
          fch_d   = is_hit && (others == '0);
          nfch_d  = is_hit && (others != '0);
          clear_d = is_hit ? sel_oh : '0;
          state_d = StIssue;
        end
        StIssue: begin
          rr_ptr_d = (sel_q == SelW'(N_HOLES - 1)) ? '0 : sel_q + SelW'(1);
          if (miss_q) begin
            state_d   = StLockout;
            cnt_d     = LoadVal;
            locked_d  = 1'b1;
            pending_d = '0;
          end else begin
            state_d = StSettle;
          end
        end
        StSettle: state_d = StIdle;
        StLockout: begin
          pending_d = '0;
          if (cnt_q <= CntW'(1)) begin
            cnt_d   = '0;
            state_d = StIdle;
          end else begin
            cnt_d    = cnt_q - CntW'(1);
            locked_d = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      pending_q <= '0;
      sel_q     <= '0;
      rr_ptr_q  <= '0;
      cnt_q     <= '0;
      miss_q    <= 1'b0;
      nfch_q    <= 1'b0;
      fch_q     <= 1'b0;
      clear_q   <= '0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      sel_q     <= sel_d;
      rr_ptr_q  <= rr_ptr_d;
      cnt_q     <= cnt_d;
      miss_q    <= miss_d;
      nfch_q    <= nfch_d;
      fch_q     <= fch_d;
      clear_q   <= clear_d;
      locked_q  <= locked_d;
    end
  end

  assign miss               = miss_q;
  assign non_full_clear_hit = nfch_q;
  assign full_clear_hit     = fch_q;
  assign clear_mole         = clear_q;
  assign locked             = locked_q;

endmodule

// File: tb/tb_hit_arbiter.sv
// Bench for hit_arbiter: vector table plus hand sequences; event pulses are checked by a
// cycle-stamped scoreboard.
module tb_hit_arbiter;

  logic       clk;
  logic       rst;
  logic       game_en;
  logic [7:0] hit_req;
  logic [7:0] mole_active;
  logic       miss;
  logic       non_full_clear_hit;
  logic       full_clear_hit;
  logic [7:0] clear_mole;
  logic       locked;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    int         at;
    logic       m;
    logic       nf;
    logic       fc;
    logic [7:0] clr;
  } exp_t;

  typedef struct {
    logic [7:0] mole;
    logic [7:0] req;
    logic       m;
    logic       nf;
    logic       fc;
    logic [7:0] clr;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[8];

  hit_arbiter #(
    .N_HOLES       (8),
    .LOCKOUT_CYCLES(10)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .game_en           (game_en),
    .hit_req           (hit_req),
    .mole_active       (mole_active),
    .miss              (miss),
    .non_full_clear_hit(non_full_clear_hit),
    .full_clear_hit    (full_clear_hit),
    .clear_mole        (clear_mole),
    .locked            (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Every pulse must match the oldest expectation, in the expected cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (miss || non_full_clear_hit || full_clear_hit || (clear_mole != 8'h00)) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_pulse: cycle %0d got miss=%b nf=%b fc=%b clr=%b, required none",
                   cyc, miss, non_full_clear_hit, full_clear_hit, clear_mole);
        end else begin
          e = sb.pop_front();
          if ({miss, non_full_clear_hit, full_clear_hit, clear_mole} !== {e.m, e.nf, e.fc, e.clr}
              || cyc != e.at) begin
            n_fail++;
            $display("FAIL pulse: cycle %0d got miss=%b nf=%b fc=%b clr=%b, required cycle %0d miss=%b nf=%b fc=%b clr=%b",
                     cyc, miss, non_full_clear_hit, full_clear_hit, clear_mole,
                     e.at, e.m, e.nf, e.fc, e.clr);
          end
        end
      end else if (sb.size() != 0 && sb[0].at <= cyc) begin
        e = sb.pop_front();
        n_cmp++;
        n_fail++;
        $display("FAIL missing_pulse: cycle %0d got no pulse, required miss=%b nf=%b fc=%b clr=%b",
                 cyc, e.m, e.nf, e.fc, e.clr);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: cycle %0d got %0h, required %0h", name, cyc, act, req);
    end
  endtask

  task automatic expect_pulse(input int at, input logic m, input logic nf, input logic fc,
                              input logic [7:0] clr);
    exp_t e;
    e.at  = at;
    e.m   = m;
    e.nf  = nf;
    e.fc  = fc;
    e.clr = clr;
    sb.push_back(e);
  endtask

  task automatic press(input logic [7:0] r);
    hit_req = r;
    tick(1);
    hit_req = 8'h00;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_miss"},   32'(miss), 32'd0);
    check({tag, "_nf"},     32'(non_full_clear_hit), 32'd0);
    check({tag, "_fc"},     32'(full_clear_hit), 32'd0);
    check({tag, "_clr"},    32'(clear_mole), 32'd0);
    check({tag, "_locked"}, 32'(locked), 32'd0);
  endtask

  initial begin
    int c;
    vecs[0] = '{8'h05, 8'h01, 1'b0, 1'b1, 1'b0, 8'h01};
    vecs[1] = '{8'h10, 8'h10, 1'b0, 1'b0, 1'b1, 8'h10};
    vecs[2] = '{8'h00, 8'h04, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[3] = '{8'h80, 8'h80, 1'b0, 1'b0, 1'b1, 8'h80};
    vecs[4] = '{8'h81, 8'h80, 1'b0, 1'b1, 1'b0, 8'h80};
    vecs[5] = '{8'hFE, 8'h01, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[6] = '{8'h08, 8'h08, 1'b0, 1'b0, 1'b1, 8'h08};
    vecs[7] = '{8'hFF, 8'h20, 1'b0, 1'b1, 1'b0, 8'h20};

    rst = 1'b1;
    game_en = 1'b0;
    hit_req = 8'h00;
    mole_active = 8'h00;
    tick(2);
    check_outputs_zero("reset");
    rst = 1'b0;
    game_en = 1'b1;
    tick(2);

    // Single presses: latency of 3 and classification.
    for (int i = 0; i < 8; i++) begin
      mole_active = vecs[i].mole;
      tick(1);
      c = cyc;
      expect_pulse(c + 3, vecs[i].m, vecs[i].nf, vecs[i].fc, vecs[i].clr);
      press(vecs[i].req);
      tick(20);
    end

    // Miss, lockout of exactly 10 cycles, press during lockout discarded.
    mole_active = 8'h00;
    c = cyc;
    expect_pulse(c + 3, 1'b1, 1'b0, 1'b0, 8'h00);
    press(8'h04);
    while (cyc <= c + 15) begin
      hit_req = (cyc == c + 6) ? 8'h20 : 8'h00;
      check("lockout_locked", 32'(locked), 32'((cyc >= c + 4) && (cyc <= c + 13)));
      tick(1);
    end
    hit_req = 8'h00;
    mole_active = 8'h20;
    c = cyc;
    expect_pulse(c + 3, 1'b0, 1'b0, 1'b1, 8'h20);
    press(8'h20);
    tick(10);

    // Reset in the middle of lockout drops locked at once.
    mole_active = 8'h00;
    c = cyc;
    expect_pulse(c + 3, 1'b1, 1'b0, 1'b0, 8'h00);
    press(8'h01);
    tick(5);
    check("lockout_before_rst", 32'(locked), 32'd1);
    rst = 1'b1;
    #1;
    check_outputs_zero("rst_in_lockout");
    tick(1);
    rst = 1'b0;
    tick(15);

    // Reset during GRANT of hole 3 abandons the event; a fresh press still works.
    mole_active = 8'h08;
    press(8'h08);
    tick(1);
    rst = 1'b1;
    #1;
    check_outputs_zero("rst_in_grant");
    tick(2);
    rst = 1'b0;
    tick(10);
    c = cyc;
    expect_pulse(c + 3, 1'b0, 1'b0, 1'b1, 8'h08);
    press(8'h08);
    tick(10);

    // Three simultaneous presses from rr_ptr=0, board clearing as commanded.
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(2);
    mole_active = 8'hFF;
    c = cyc;
    expect_pulse(c + 3,  1'b0, 1'b1, 1'b0, 8'h01);
    expect_pulse(c + 7,  1'b0, 1'b1, 1'b0, 8'h02);
    expect_pulse(c + 11, 1'b0, 1'b1, 1'b0, 8'h80);
    press(8'h83);
    tick(3);
    mole_active = 8'hFE;
    tick(4);
    mole_active = 8'hFC;
    tick(4);
    mole_active = 8'h7C;
    tick(5);

    // Round-robin resumes above the last served hole (rr_ptr=3).
    mole_active = 8'hFF;
    c = cyc;
    expect_pulse(c + 3, 1'b0, 1'b1, 1'b0, 8'h04);
    press(8'h04);
    tick(8);
    c = cyc;
    expect_pulse(c + 3,  1'b0, 1'b1, 1'b0, 8'h80);
    expect_pulse(c + 7,  1'b0, 1'b1, 1'b0, 8'h01);
    expect_pulse(c + 11, 1'b0, 1'b1, 1'b0, 8'h04);
    press(8'h85);
    tick(15);

    // Re-press of the granted hole during GRANT is served again and misses.
    mole_active = 8'h01;
    c = cyc;
    expect_pulse(c + 3, 1'b0, 1'b0, 1'b1, 8'h01);
    expect_pulse(c + 7, 1'b1, 1'b0, 1'b0, 8'h00);
    press(8'h01);
    tick(1);
    press(8'h01);
    tick(1);
    mole_active = 8'h00;
    tick(20);

    // game_en low discards pending holes and resets rr_ptr.
    mole_active = 8'hFF;
    c = cyc;
    expect_pulse(c + 3, 1'b0, 1'b1, 1'b0, 8'h04);
    press(8'h04);
    tick(8);
    press(8'h07);
    game_en = 1'b0;
    tick(5);
    game_en = 1'b1;
    tick(10);
    c = cyc;
    expect_pulse(c + 3, 1'b0, 1'b1, 1'b0, 8'h01);
    expect_pulse(c + 7, 1'b0, 1'b1, 1'b0, 8'h80);
    press(8'h81);
    tick(12);

    check("scoreboard_drain", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
